// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the round-robin AHB arbiter: state encoding,
// default bridge select mask and the owner-index width helper.
package ahb_arb_pkg;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] GRANT       = 2'd1;
  localparam logic [1:0] BRIDGE_WAIT = 2'd2;
  localparam logic [1:0] BRIDGE_OWN  = 2'd3;

  localparam logic [3:0] DEF_BRIDGE_MASK = 4'b1100;

  // A single master still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching upward from base+1,
// wrapping past NUM_MASTERS-1 back to 0.
module rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDXW        = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDXW-1:0]        base,
  output logic [IDXW-1:0]        winner,
  output logic                   valid
);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // base itself is visited last, so the previous owner has lowest priority.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!valid && req[(int'(base) + i) % NUM_MASTERS]) begin
        valid  = 1'b1;
        winner = IDXW'((int'(base) + i) % NUM_MASTERS);
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with bridge forwarding (hreqb/hgrantb handshake).
// Optional ownership watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int               NUM_MASTERS    = 4,
  parameter int               SEL_W          = 4,
  parameter logic [SEL_W-1:0] BRIDGE_MASK    = SEL_W'(DEF_BRIDGE_MASK),
  parameter int               TIMEOUT_CYCLES = 256,
  localparam int              IDXW           = idx_width(NUM_MASTERS)
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [NUM_MASTERS-1:0]       hreq,
  input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
  input  logic                         hready_out,
  input  logic                         hresp,
  input  logic                         hgrantb,
  output logic [NUM_MASTERS-1:0]       hgrant,
  output logic [SEL_W-1:0]             sel,
  output logic                         hreqb,
  output logic [IDXW-1:0]              owner,
  output logic                         busy,
  output logic                         timeout_err
);

  logic [1:0]       state;
  logic [IDXW-1:0]  last;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_sel;
  logic             tr_done;
  logic             to_hit;

  assign tr_done  = hready_out && !hresp;
  assign pick_sel = sel_in[pick_idx*SEL_W +: SEL_W];

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDXW        (IDXW)
  ) u_pick (
    .req    (hreq),
    .base   (last),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wdog_cnt;

  // Held at zero outside an ownership, so it is clear on every entry.
  always_ff @(posedge hclk) begin
    if (hreset || state == IDLE || state == BRIDGE_WAIT) wdog_cnt <= '0;
    else if (!tr_done)                                   wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign to_hit = (wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= IDLE;
      hgrant      <= '0;
      sel         <= '0;
      hreqb       <= 1'b0;
      owner       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last        <= IDXW'(NUM_MASTERS - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            sel   <= pick_sel;
            busy  <= 1'b1;
            if (|(pick_sel & BRIDGE_MASK)) begin
              state <= BRIDGE_WAIT;
              hreqb <= 1'b1;
            end else begin
              state  <= GRANT;
              hgrant <= NUM_MASTERS'(1) << pick_idx;
            end
          end
        end
        GRANT: begin
          if (tr_done || to_hit) begin
            state       <= IDLE;
            hgrant      <= '0;
            sel         <= '0;
            busy        <= 1'b0;
            last        <= owner;
            timeout_err <= !tr_done;
          end
        end
        BRIDGE_WAIT: begin
          if (hgrantb) begin
            state  <= BRIDGE_OWN;
            hgrant <= NUM_MASTERS'(1) << owner;
          end else if (!hreq[owner]) begin
            // Abandoned before the bridge answered: pointer not advanced.
            state <= IDLE;
            hreqb <= 1'b0;
            sel   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (tr_done || to_hit) begin
            state       <= IDLE;
            hgrant      <= '0;
            hreqb       <= 1'b0;
            sel         <= '0;
            busy        <= 1'b0;
            last        <= owner;
            timeout_err <= !tr_done;
          end else if (!hgrantb) begin
            state  <= BRIDGE_WAIT;
            hgrant <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter; timeout scenario built with ARB_TIMEOUT_EN.
module tb_ahb_rr_arbiter;

  localparam int NM = 4;
  localparam int SW = 4;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [NM-1:0] hreq;
  logic [NM*SW-1:0] sel_in;
  logic          hready_out;
  logic          hresp;
  logic          hgrantb;
  logic [NM-1:0] hgrant;
  logic [SW-1:0] sel;
  logic          hreqb;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .SEL_W          (SW),
    .BRIDGE_MASK    (4'b1100),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hreq        (hreq),
    .sel_in      (sel_in),
    .hready_out  (hready_out),
    .hresp       (hresp),
    .hgrantb     (hgrantb),
    .hgrant      (hgrant),
    .sel         (sel),
    .hreqb       (hreqb),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset     = 1'b1;
    hreq       = '0;
    sel_in     = '0;
    hready_out = 1'b0;
    hresp      = 1'b0;
    hgrantb    = 1'b0;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({hgrant, sel, hreqb, owner, busy, timeout_err} !== 13'b0) begin
      bad++;
      $display("FAIL reset: got grant=%b sel=%h hreqb=%b owner=%0d busy=%b to=%b want all zero",
               hgrant, sel, hreqb, owner, busy, timeout_err);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    hreq = 4'b0101; sel_in = 16'h1111; hready_out = 1'b1;
    tick();
    total++;
    if ({hgrant, owner, sel, busy} !== {4'b0001, 2'd0, 4'h1, 1'b1}) begin
      bad++;
      $display("FAIL alt_c1: got grant=%b owner=%0d sel=%h busy=%b want 0001/0/1/1", hgrant, owner, sel, busy);
    end
    tick();
    total++;
    if ({hgrant, sel, busy} !== 9'b0) begin
      bad++;
      $display("FAIL alt_c2: got grant=%b sel=%h busy=%b want 0000/0/0", hgrant, sel, busy);
    end
    tick();
    total++;
    if ({hgrant, owner} !== {4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL alt_c3: got grant=%b owner=%0d want 0100/2", hgrant, owner);
    end
    hreq = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g [9];
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    hreq = 4'b1111; sel_in = 16'h1111; hready_out = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (hgrant !== exp_g[i]) begin
        bad++;
        $display("FAIL rr_step%0d: got grant=%b want %b", i, hgrant, exp_g[i]);
      end
    end
    hreq = '0;
    tick();
  endtask

  task automatic test_bridge();
    do_reset();
    hreq = 4'b0010; sel_in = 16'h0040; hready_out = 1'b1; hgrantb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({hreqb, hgrant, busy, owner} !== {1'b1, 4'b0000, 1'b1, 2'd1}) begin
        bad++;
        $display("FAIL bridge_wait%0d: got hreqb=%b grant=%b busy=%b owner=%0d want 1/0000/1/1",
                 i, hreqb, hgrant, busy, owner);
      end
    end
    hgrantb = 1'b1; hready_out = 1'b0;
    tick();
    total++;
    if ({hreqb, hgrant} !== {1'b1, 4'b0010}) begin
      bad++;
      $display("FAIL bridge_own: got hreqb=%b grant=%b want 1/0010", hreqb, hgrant);
    end
    hready_out = 1'b1; hreq = '0;
    tick();
    total++;
    if ({hreqb, hgrant, busy} !== 6'b0) begin
      bad++;
      $display("FAIL bridge_done: got hreqb=%b grant=%b busy=%b want 0/0000/0", hreqb, hgrant, busy);
    end
    hgrantb = 1'b0;
  endtask

  task automatic test_error_hold();
    do_reset();
    hreq = 4'b1000; sel_in = 16'h1111; hready_out = 1'b0;
    tick();
    total++;
    if (hgrant !== 4'b1000) begin
      bad++;
      $display("FAIL err_grant: got grant=%b want 1000", hgrant);
    end
    hresp = 1'b1; hready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (hgrant !== 4'b1000) begin
        bad++;
        $display("FAIL err_hold%0d: got grant=%b want 1000", i, hgrant);
      end
    end
    hresp = 1'b0; hreq = '0;
    tick();
    total++;
    if ({hgrant, sel, busy} !== 9'b0) begin
      bad++;
      $display("FAIL err_release: got grant=%b sel=%h busy=%b want 0000/0/0", hgrant, sel, busy);
    end
  endtask

  task automatic test_reset_in_bridge();
    do_reset();
    // Master 2 completes first so the pointer is no longer at its reset value.
    hreq = 4'b0100; sel_in = 16'h0100; hready_out = 1'b1;
    tick();
    tick();
    hreq = 4'b0010; sel_in = 16'h0080; hready_out = 1'b0; hgrantb = 1'b1;
    tick();
    tick();
    total++;
    if ({hreqb, hgrant} !== {1'b1, 4'b0010}) begin
      bad++;
      $display("FAIL rb_own: got hreqb=%b grant=%b want 1/0010", hreqb, hgrant);
    end
    hgrantb = 1'b0;
    tick();
    total++;
    if ({hreqb, hgrant, busy} !== {1'b1, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL rb_regrant_wait: got hreqb=%b grant=%b busy=%b want 1/0000/1", hreqb, hgrant, busy);
    end
    hgrantb = 1'b1;
    tick();
    total++;
    if (hgrant !== 4'b0010) begin
      bad++;
      $display("FAIL rb_reown: got grant=%b want 0010", hgrant);
    end
    hreset = 1'b1;
    tick();
    total++;
    if ({hgrant, hreqb, busy, owner, sel} !== 12'b0) begin
      bad++;
      $display("FAIL rb_reset: got grant=%b hreqb=%b busy=%b owner=%0d sel=%h want zeros",
               hgrant, hreqb, busy, owner, sel);
    end
    hreset = 1'b0; hgrantb = 1'b0; hreq = 4'b1111; sel_in = 16'h1111;
    tick();
    total++;
    if (hgrant !== 4'b0001) begin
      bad++;
      $display("FAIL rb_prio: got grant=%b want 0001", hgrant);
    end
    hreq = '0; hready_out = 1'b1;
    tick();
  endtask

  task automatic test_drop_in_wait();
    do_reset();
    hreq = 4'b0010; sel_in = 16'h0040; hgrantb = 1'b0; hready_out = 1'b1;
    tick();
    hreq = 4'b0000;
    tick();
    total++;
    if ({hreqb, busy, hgrant} !== 6'b0) begin
      bad++;
      $display("FAIL drop_idle: got hreqb=%b busy=%b grant=%b want 0/0/0000", hreqb, busy, hgrant);
    end
    hreq = 4'b1111; sel_in = 16'h1111;
    tick();
    total++;
    if (hgrant !== 4'b0001) begin
      bad++;
      $display("FAIL drop_last_kept: got grant=%b want 0001", hgrant);
    end
    hreq = '0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    hreq = 4'b0011; sel_in = 16'h1111; hready_out = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if ({hgrant, timeout_err} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL to_hold%0d: got grant=%b to=%b want 0001/0", i, hgrant, timeout_err);
      end
    end
    tick();
    total++;
    if ({hgrant, timeout_err, busy} !== {4'b0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL to_fire: got grant=%b to=%b busy=%b want 0000/1/0", hgrant, timeout_err, busy);
    end
    tick();
    total++;
    if ({hgrant, timeout_err} !== {4'b0010, 1'b0}) begin
      bad++;
      $display("FAIL to_next: got grant=%b to=%b want 0010/0", hgrant, timeout_err);
    end
    hreq = '0; hready_out = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    hreq = 4'b0011; sel_in = 16'h1111; hready_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({hgrant, timeout_err} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL stall%0d: got grant=%b to=%b want 0001/0", i, hgrant, timeout_err);
      end
    end
    hreq = '0; hready_out = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_round_robin();
    test_bridge();
    test_error_hold();
    test_reset_in_bridge();
    test_drop_in_wait();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule
